eep_seq: RTL

- Sequences all accesses to the 4-word, 14-bit EEPROM shared by two requesters: requester 0 (digital core coefficient fetch) and requester 1 (configuration command path).
- Arbitrates round-robin, drives eep_cs_n/eep_r_w_n/eep_addr/eep_wdata, and captures read data.
- On writes, holds chrg_pmp_en for the full programming window.
- Sits between the digital core / cfg command decode and the EEPROM pins.

---
 rtl/eep_seq_pkg.sv | 41 ++++
 rtl/eep_rr_arb.sv | 31 +++
 rtl/eep_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/eep_seq_pkg.sv
// Shared types and constants for the EEPROM access sequencer.
// EEP_WR_VERIFY_EN adds the VFY state used for the write read-back check.
package eep_seq_pkg;

  localparam int EEP_DW = 14;
  localparam int EEP_AW = 2;

  localparam int RD_CYC_DEF    = 4;
  localparam int SETUP_CYC_DEF = 2;
  localparam int PMP_CYC_DEF   = 2400000;
  localparam int REC_CYC_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PUMP  = 3'd3,
`ifdef EEP_WR_VERIFY_EN
    REC      = 3'd4,
    VFY      = 3'd5
`else
    REC      = 3'd4
`endif
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // States in which the EEPROM chip select is driven low.
  function automatic logic cs_active(input state_t s);
    case (s)
      RD, WR_SETUP, WR_PUMP: return 1'b1;
`ifdef EEP_WR_VERIFY_EN
      VFY:                   return 1'b1;
`endif
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/eep_rr_arb.sv
// Two-requester round-robin arbiter. The winner is combinational; the
// priority pointer flips to the other requester whenever a grant is taken.
module eep_rr_arb
  import eep_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win,
  output logic       win_idx,
  output logic       any
);

  logic ptr;

  // Pick the pointer requester if it asks, otherwise the other one.
  always_comb begin
    any     = |req;
    win_idx = req[ptr] ? ptr : ~ptr;
    win     = '0;
    if (any) win[win_idx] = 1'b1;
  end

  // Pointer moves away from whoever was just granted.
  always_ff @(posedge clk) begin
    if (rst) ptr <= 1'b0;
    else if (take && any) ptr <= ~win_idx;
  end

endmodule

// File: rtl/eep_seq.sv
// EEPROM access sequencer: round-robin between two requesters, drives the
// EEPROM pins, holds the charge pump for the programming window.
// Optional write read-back check is enabled with EEP_WR_VERIFY_EN.
//
// state    | meaning
// IDLE     | no access, arbitrate pending requests
// RD       | cs low for RD_CYC cycles, capture read data on the last one
// WR_SETUP | cs low, r_w_n low, addr/data settling before the pump
// WR_PUMP  | charge pump on for PMP_CYC cycles
// REC      | cs high recovery for REC_CYC cycles
// VFY      | automatic read-back of the just-written word (optional)
module eep_seq
  import eep_seq_pkg::*;
#(
  parameter int RD_CYC    = RD_CYC_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PMP_CYC   = PMP_CYC_DEF,
  parameter int REC_CYC   = REC_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        r_w_n,
  input  logic [EEP_AW-1:0] addr0,
  input  logic [EEP_AW-1:0] addr1,
  input  logic [EEP_DW-1:0] wdata0,
  input  logic [EEP_DW-1:0] wdata1,
  input  logic [EEP_DW-1:0] eep_rd_data,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [EEP_DW-1:0] rd_data,
  output logic              busy,
  output logic              verify_err,
  output logic              eep_cs_n,
  output logic              eep_r_w_n,
  output logic [EEP_AW-1:0] eep_addr,
  output logic [EEP_DW-1:0] eep_wdata,
  output logic              chrg_pmp_en
);

  localparam int CMAX = max_of(max_of(RD_CYC, SETUP_CYC), max_of(PMP_CYC, REC_CYC));
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RD_LD    = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PMP_LD   = CW'(PMP_CYC - 1);
  localparam logic [CW-1:0] REC_LD   = CW'(REC_CYC - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            own, own_nxt;
  logic            take, fin, cap, hold_rec;
  logic [1:0]      arb_win;
  logic            arb_idx, arb_any;

  logic [1:0]        gnt_nxt, done_nxt;
  logic [EEP_DW-1:0] rd_data_nxt, eep_wdata_nxt;
  logic [EEP_AW-1:0] eep_addr_nxt;
  logic              verr_nxt;

`ifdef EEP_WR_VERIFY_EN
  logic vfy_pend, vfy_pend_nxt;
`endif

  eep_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .take    (take),
    .win     (arb_win),
    .win_idx (arb_idx),
    .any     (arb_any)
  );

  // State register, down-counter and access owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      own   <= 1'b0;
`ifdef EEP_WR_VERIFY_EN
      vfy_pend <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      own   <= own_nxt;
`ifdef EEP_WR_VERIFY_EN
      vfy_pend <= vfy_pend_nxt;
`endif
    end
  end

  // Next-state logic; each state reloads the counter on exit and
  // leaves on terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - 1'b1;
    take      = 1'b0;
    fin       = 1'b0;
    cap       = 1'b0;
`ifdef EEP_WR_VERIFY_EN
    vfy_pend_nxt = vfy_pend;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (arb_any) begin
          take      = 1'b1;
          state_nxt = r_w_n[arb_idx] ? RD : WR_SETUP;
          cnt_nxt   = r_w_n[arb_idx] ? RD_LD : SETUP_LD;
        end
      end
      RD: if (cnt == '0) begin
        state_nxt = REC;
        cnt_nxt   = REC_LD;
        fin       = 1'b1;
        cap       = 1'b1;
      end
      WR_SETUP: if (cnt == '0) begin
        state_nxt = WR_PUMP;
        cnt_nxt   = PMP_LD;
      end
      WR_PUMP: if (cnt == '0) begin
        state_nxt = REC;
        cnt_nxt   = REC_LD;
`ifdef EEP_WR_VERIFY_EN
        vfy_pend_nxt = 1'b1;
`else
        fin = 1'b1;
`endif
      end
      REC: if (cnt == '0) begin
`ifdef EEP_WR_VERIFY_EN
        if (vfy_pend) begin
          state_nxt = VFY;
          cnt_nxt   = RD_LD;
        end else begin
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
`ifdef EEP_WR_VERIFY_EN
      VFY: if (cnt == '0) begin
        state_nxt    = REC;
        cnt_nxt      = REC_LD;
        fin          = 1'b1;
        cap          = 1'b1;
        vfy_pend_nxt = 1'b0;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values, derived from the upcoming state so every pin is a flop.
  always_comb begin
    own_nxt = take ? arb_idx : own;
`ifdef EEP_WR_VERIFY_EN
    hold_rec = (state_nxt == REC) && vfy_pend_nxt;
    verr_nxt = fin && (state == VFY) && (eep_rd_data != eep_wdata);
`else
    hold_rec = 1'b0;
    verr_nxt = 1'b0;
`endif
    gnt_nxt = '0;
    if (cs_active(state_nxt) || hold_rec) gnt_nxt[own_nxt] = 1'b1;
    done_nxt = '0;
    if (fin) done_nxt[own] = 1'b1;
    rd_data_nxt   = cap ? eep_rd_data : rd_data;
    eep_addr_nxt  = take ? (arb_idx ? addr1 : addr0) : eep_addr;
    eep_wdata_nxt = take ? (arb_idx ? wdata1 : wdata0) : eep_wdata;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      done        <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      verify_err  <= 1'b0;
      eep_cs_n    <= 1'b1;
      eep_r_w_n   <= 1'b1;
      eep_addr    <= '0;
      eep_wdata   <= '0;
      chrg_pmp_en <= 1'b0;
    end else begin
      gnt         <= gnt_nxt;
      done        <= done_nxt;
      rd_data     <= rd_data_nxt;
      busy        <= (state_nxt != IDLE);
      verify_err  <= verr_nxt;
      eep_cs_n    <= ~cs_active(state_nxt);
      eep_r_w_n   <= ~((state_nxt == WR_SETUP) || (state_nxt == WR_PUMP));
      eep_addr    <= eep_addr_nxt;
      eep_wdata   <= eep_wdata_nxt;
      chrg_pmp_en <= (state_nxt == WR_PUMP);
    end
  end

  logic unused_win;
  assign unused_win = ^arb_win;

endmodule
